framebuffer_read_master: RTL

- Avalon-MM read master. Fetches a linear pixel buffer from SDRAM: base address plus word count, consecutive 32-bit words.
- Presents the words in order on a valid/ready pixel stream for the VGA output path. It is the read-side counterpart of the SDRAM pixel-fill write master.
- Uses pipelined reads with variable latency (readdatavalid). Credit-limited so the internal FIFO can never overflow.

---
 rtl/framebuffer_read_master_pkg.sv | 18 +
 rtl/framebuffer_read_master_if.sv | 46 ++++
 rtl/framebuffer_read_master_sync_fifo.sv | 58 +++++
 rtl/framebuffer_read_master.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/framebuffer_read_master_pkg.sv
// Shared types and constants for the VGA framebuffer DMA path.
//   state_t      - read master FSM states
//   SDRAM_ADDR   - default framebuffer base in SDRAM
//   FRAME_WORDS  - words in one 640x480 frame (one 32-bit word per pixel)
//   BytesPerWord - address stride between consecutive bus words
package framebuffer_read_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_t;

  localparam logic [31:0] SDRAM_ADDR   = 32'h0800_0000;
  localparam int unsigned FRAME_WORDS  = 307200;
  localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/framebuffer_read_master_if.sv
// Bus bundle for the framebuffer read master.
//   Avalon-MM read side : master_address, master_read, master_readdata,
//                         master_readdatavalid, master_waitrequest
//   Pixel stream side   : pix_data, pix_valid, pix_ready, pix_first
// Modport master is the DMA engine; modport slave is the memory plus pixel consumer.
interface framebuffer_read_master_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();

  logic [AddrWidth-1:0] master_address;
  logic                 master_read;
  logic [DataWidth-1:0] master_readdata;
  logic                 master_readdatavalid;
  logic                 master_waitrequest;

  logic [DataWidth-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_first;

  modport master (
    output master_address,
    output master_read,
    input  master_readdata,
    input  master_readdatavalid,
    input  master_waitrequest,
    output pix_data,
    output pix_valid,
    output pix_first,
    input  pix_ready
  );

  modport slave (
    input  master_address,
    input  master_read,
    output master_readdata,
    output master_readdatavalid,
    output master_waitrequest,
    input  pix_data,
    input  pix_valid,
    input  pix_first,
    output pix_ready
  );

endinterface

// File: rtl/framebuffer_read_master_sync_fifo.sv
// Synchronous show-ahead FIFO used as the pixel buffer.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i : write request and data; ignored when full
//   pop_i         : consume head word; ignored when empty
//   data_o        : head word (registered storage), zero while empty
//   count_o       : occupancy; empty_o / full_o status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module framebuffer_read_master_sync_fifo #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATAWIDTH-1:0]         data_i,
  output logic [DATAWIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthL = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthL);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Storage is not reset; the empty flag masks whatever it holds.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/framebuffer_read_master.sv
// Avalon-MM read master that streams a linear pixel buffer out of SDRAM.
//   clk, reset_n          : clock, synchronous active-low reset
//   start                 : one-cycle request, sampled only while idle
//   base_address          : first byte address of the buffer
//   word_count            : number of 32-bit words to fetch (0 = just pulse done)
//   busy / done           : transfer in progress / one-cycle completion pulse
//   bus (master modport)  : Avalon pipelined read port and valid/ready pixel stream
// Reads are issued only while a FIFO slot is reserved for every outstanding read,
// so returned data can always be written without backpressure on the bus.
module framebuffer_read_master
  import framebuffer_read_master_pkg::*;
#(
  parameter int unsigned MASTER_ADDRESSWIDTH = 32,
  parameter int unsigned DATAWIDTH           = 32,
  parameter int unsigned COUNTWIDTH          = 24,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned MAX_PENDING         = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_address,
  input  logic [COUNTWIDTH-1:0]          word_count,
  output logic                           busy,
  output logic                           done,
  framebuffer_read_master_if.master      bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0]   DepthL   = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] MaxPendL = CntW'(MAX_PENDING);
  localparam logic [MASTER_ADDRESSWIDTH-1:0] AddrStep = MASTER_ADDRESSWIDTH'(BytesPerWord);
  localparam logic [COUNTWIDTH-1:0] OneCnt = COUNTWIDTH'(1);

  state_t                         state_q, state_d;
  logic [MASTER_ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [COUNTWIDTH-1:0]          issue_left_q, issue_left_d;
  logic [COUNTWIDTH-1:0]          drain_left_q, drain_left_d;
  logic [CntW-1:0]                pending_q, pending_d;
  logic                           first_q, first_d;
  logic                           zero_done_q, zero_done_d;

  logic [CntW-1:0]      fifo_count;
  logic                 fifo_empty;
  logic                 unused_fifo_full;
  logic [DATAWIDTH-1:0] fifo_head;
  logic [CntW:0]        credit_used;
  logic                 rd_req, rd_acc, push, pop, last_pop;

  // Returns with nothing outstanding are leftovers from an aborted transfer.
  assign push = bus.master_readdatavalid && (pending_q != '0);
  assign pop  = !fifo_empty && bus.pix_ready;

  // Reads in flight plus words buffered must fit in the FIFO. While a request is
  // stalled this sum cannot grow, so master_read stays asserted through the stall.
  assign credit_used = {1'b0, pending_q} + {1'b0, fifo_count};
  assign rd_req = (state_q == StRead) && (issue_left_q != '0) &&
                  (pending_q < MaxPendL) && (credit_used < DepthL);
  assign rd_acc = rd_req && !bus.master_waitrequest;

  assign last_pop = (state_q == StDrain) && pop && (drain_left_q == OneCnt);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    drain_left_d = drain_left_q;
    first_d      = first_q;
    zero_done_d  = 1'b0;
    pending_d    = pending_q + CntW'(rd_acc) - CntW'(push);

    if (pop && (state_q != StIdle)) begin
      drain_left_d = drain_left_q - OneCnt;
      first_d      = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d       = base_address;
            issue_left_d = word_count;
            drain_left_d = word_count;
            first_d      = 1'b1;
            state_d      = StRead;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_acc) begin
          addr_d       = addr_q + AddrStep;
          issue_left_d = issue_left_q - OneCnt;
          if (issue_left_q == OneCnt) state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      drain_left_q <= '0;
      pending_q    <= '0;
      first_q      <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      drain_left_q <= drain_left_d;
      pending_q    <= pending_d;
      first_q      <= first_d;
      zero_done_q  <= zero_done_d;
    end
  end

  framebuffer_read_master_sync_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.master_readdata),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (unused_fifo_full)
  );

  assign busy               = (state_q != StIdle);
  assign done               = zero_done_q || last_pop;
  assign bus.master_read    = rd_req;
  assign bus.master_address = addr_q;
  assign bus.pix_data       = fifo_head;
  assign bus.pix_valid      = !fifo_empty;
  assign bus.pix_first      = first_q && !fifo_empty;

endmodule
